tpu_host_loader: RTL



---
 rtl/tpu_host_pkg.sv | 30 +++
 rtl/host_run_watchdog.sv | 33 +++
 rtl/tpu_host_loader.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tpu_host_pkg.sv
`default_nettype none
// ============================================================================
// tpu_host_pkg : shared header layout, opcodes and loader states
// Revision     : 1.0
// ============================================================================
package tpu_host_pkg;

    typedef enum logic [1:0] {
        OP_NOP       = 2'b00,
        OP_WR_WEIGHT = 2'b01,
        OP_WR_INPUT  = 2'b10,
        OP_RUN       = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        HDR       = 2'd0,
        WRITE     = 2'd1,
        RUN_START = 2'd2,
        RUN_WAIT  = 2'd3
    } state_e;

    localparam int HDR_OP_LSB   = 14;
    localparam int HDR_OP_W     = 2;
    localparam int HDR_BASE_LSB = 8;
    localparam int HDR_BASE_W   = 6;
    localparam int HDR_LEN_LSB  = 0;
    localparam int HDR_LEN_W    = 8;

endpackage
`default_nettype wire

// File: rtl/host_run_watchdog.sv
`default_nettype none
// ============================================================================
// host_run_watchdog : clear/enable cycle counter, terminal flag at TIMEOUT-1
// Revision          : 1.0
// ============================================================================
module host_run_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic term_o
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Holds at the terminal value so the flag can never be missed by a wrap.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != TERM)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign term_o = (cnt_q == TERM);

endmodule
`default_nettype wire

// File: rtl/tpu_host_loader.sv
`default_nettype none
// ============================================================================
// tpu_host_loader : host stream decoder, memory writer and run sequencer
// Revision        : 1.0
// ============================================================================
module tpu_host_loader
    import tpu_host_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 6,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              mem_we,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              tpu_start,
    input  logic              tpu_done,
    output logic              busy,
    output logic              done_pulse,
    output logic              err_ovf,
    output logic              err_timeout,
    input  logic              err_clr
);

    state_e                 state_q;
    logic [ADDR_W:0]        addr_q;
    logic [HDR_LEN_W-1:0]   rem_q;
    logic                   sel_q;
    logic                   mem_we_q;
    logic                   mem_sel_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [DATA_W-1:0]      mem_wdata_q;
    logic                   tpu_start_q;
    logic                   done_pulse_q;
    logic                   err_ovf_q;
    logic                   err_timeout_q;

    logic    w_xfer;
    logic    w_wd_term;
    opcode_e w_op;

    assign s_ready = (state_q == HDR) || (state_q == WRITE);
    assign busy    = (state_q != HDR);
    assign w_xfer  = s_valid && s_ready;
    assign w_op    = opcode_e'(s_data[HDR_OP_LSB +: HDR_OP_W]);

    host_run_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr_i  (state_q == RUN_START),
        .en_i   (state_q == RUN_WAIT),
        .term_o (w_wd_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= HDR;
            addr_q        <= '0;
            rem_q         <= '0;
            sel_q         <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_sel_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            tpu_start_q   <= 1'b0;
            done_pulse_q  <= 1'b0;
            err_ovf_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            mem_we_q     <= 1'b0;
            tpu_start_q  <= 1'b0;
            done_pulse_q <= 1'b0;
            // Clear first so a same-cycle set event below takes priority.
            if (err_clr) begin
                err_ovf_q     <= 1'b0;
                err_timeout_q <= 1'b0;
            end
            case (state_q)
                HDR: begin
                    if (w_xfer) begin
                        case (w_op)
                            OP_WR_WEIGHT, OP_WR_INPUT: begin
                                sel_q   <= (w_op == OP_WR_INPUT);
                                addr_q  <= {1'b0, s_data[HDR_BASE_LSB +: ADDR_W]};
                                rem_q   <= s_data[HDR_LEN_LSB +: HDR_LEN_W];
                                state_q <= WRITE;
                            end
                            OP_RUN: begin
                                tpu_start_q <= 1'b1;
                                state_q     <= RUN_START;
                            end
                            default: ;
                        endcase
                    end
                end
                WRITE: begin
                    if (w_xfer) begin
                        // Top address bit marks the beat as beyond the memory; it saturates there.
                        if (!addr_q[ADDR_W]) begin
                            mem_we_q    <= 1'b1;
                            mem_sel_q   <= sel_q;
                            mem_addr_q  <= addr_q[ADDR_W-1:0];
                            mem_wdata_q <= s_data;
                            addr_q      <= addr_q + 1'b1;
                        end else begin
                            err_ovf_q <= 1'b1;
                        end
                        rem_q <= rem_q - 1'b1;
                        if (rem_q == '0) begin
                            state_q <= HDR;
                        end
                    end
                end
                RUN_START: begin
                    state_q <= RUN_WAIT;
                end
                RUN_WAIT: begin
                    if (tpu_done) begin
                        done_pulse_q <= 1'b1;
                        state_q      <= HDR;
                    end else if (w_wd_term) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= HDR;
                    end
                end
                default: begin
                    state_q <= HDR;
                end
            endcase
        end
    end

    assign mem_we      = mem_we_q;
    assign mem_sel     = mem_sel_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign tpu_start   = tpu_start_q;
    assign done_pulse  = done_pulse_q;
    assign err_ovf     = err_ovf_q;
    assign err_timeout = err_timeout_q;

endmodule
`default_nettype wire
